// File: rtl/fde_cpu.sv
// Minimal 8-bit fetch-decode-execute processor running a fixed 16-word ROM
// against a 16x8 register file; every register write is exposed on the outputs.
module fde_cpu (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_stop,
   output logic [3:0] o_write_add,
   output logic [7:0] o_write_data
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   function automatic logic [15:0] rom_word(input logic [3:0] addr);
      case (addr)
         4'd0:    rom_word = 16'h1105;
         4'd1:    rom_word = 16'h1203;
         4'd2:    rom_word = 16'h2312;
         4'd3:    rom_word = 16'h3412;
         4'd4:    rom_word = 16'h4512;
         4'd5:    rom_word = 16'h5612;
         4'd6:    rom_word = 16'h6712;
         4'd7:    rom_word = 16'h8830;
         4'd8:    rom_word = 16'hF000;
         default: rom_word = 16'h0000;
      endcase
   endfunction

   state_t           state_r;
   state_t           state_nx_s;
   logic [3:0]       pc_r;
   logic [3:0]       pc_nx_s;
   logic [15:0]      ir_r;
   logic [7:0]       a_r;
   logic [7:0]       b_r;
   logic [15:0][7:0] regs_r;
   logic [3:0]       write_add_r;
   logic [7:0]       write_data_r;
   logic             wr_en_s;
   logic [7:0]       result_s;
   logic [3:0]       op_s;
   logic [3:0]       rd_s;
   logic [3:0]       rs_s;
   logic [3:0]       rt_s;
   logic [7:0]       imm_s;

   assign op_s  = ir_r[15:12];
   assign rd_s  = ir_r[11:8];
   assign rs_s  = ir_r[7:4];
   assign rt_s  = ir_r[3:0];
   assign imm_s = ir_r[7:0];

   // Next-state, next-PC and execute-stage result selection
   always_comb begin
      state_nx_s = state_r;
      pc_nx_s    = pc_r;
      wr_en_s    = 1'b0;
      result_s   = 8'h00;
      case (state_r)
         ST_FETCH: begin
            state_nx_s = ST_DECODE;
            pc_nx_s    = pc_r + 4'd1;
         end
         ST_DECODE: begin
            state_nx_s = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            state_nx_s = ST_FETCH;
            case (op_s)
               4'h1: begin wr_en_s = 1'b1; result_s = imm_s; end
               4'h2: begin wr_en_s = 1'b1; result_s = a_r + b_r; end
               4'h3: begin wr_en_s = 1'b1; result_s = a_r - b_r; end
               4'h4: begin wr_en_s = 1'b1; result_s = a_r & b_r; end
               4'h5: begin wr_en_s = 1'b1; result_s = a_r | b_r; end
               4'h6: begin wr_en_s = 1'b1; result_s = a_r ^ b_r; end
               4'h7: begin wr_en_s = 1'b1; result_s = a_r; end
               4'h8: begin wr_en_s = 1'b1; result_s = {a_r[6:0], 1'b0}; end
               4'h9: begin wr_en_s = 1'b1; result_s = {1'b0, a_r[7:1]}; end
               4'hA: pc_nx_s = rt_s;
               4'hB: begin
                  if (a_r == 8'h00) begin
                     pc_nx_s = rt_s;
                  end else begin
                     pc_nx_s = pc_r;
                  end
               end
               4'hF: state_nx_s = ST_HALT;
               default: begin
                  wr_en_s = 1'b0;
               end
            endcase
         end
         ST_HALT: begin
            state_nx_s = ST_HALT;
         end
         default: begin
            state_nx_s = ST_FETCH;
         end
      endcase
   end

   // All architectural state; i_stop freezes every register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_r      <= ST_FETCH;
         pc_r         <= 4'd0;
         ir_r         <= 16'h0000;
         a_r          <= 8'h00;
         b_r          <= 8'h00;
         regs_r       <= '0;
         write_add_r  <= 4'd0;
         write_data_r <= 8'h00;
      end else if (!i_stop) begin
         state_r <= state_nx_s;
         pc_r    <= pc_nx_s;
         if (state_r == ST_FETCH) begin
            ir_r <= rom_word(pc_r);
         end
         if (state_r == ST_DECODE) begin
            a_r <= regs_r[rs_s];
            b_r <= regs_r[rt_s];
         end
         if (wr_en_s) begin
            regs_r[rd_s] <= result_s;
            write_add_r  <= rd_s;
            write_data_r <= result_s;
         end
      end
   end

   assign o_write_add  = write_add_r;
   assign o_write_data = write_data_r;

endmodule

// File: tb/tb_fde_cpu.sv
// Bench for fde_cpu: directed reset/stop/abort steps, then random i_stop
// patterns checked against an instruction-level reference model.
module tb_fde_cpu;

   logic       i_clk;
   logic       i_reset;
   logic       i_stop;
   logic [3:0] o_write_add;
   logic [7:0] o_write_data;

   int tests_run;
   int tests_failed;

   // instruction-level reference model
   int rom_m [16];
   int reg_m [16];
   int pc_m;
   int run_cnt_m;
   bit halt_m;
   int exp_add;
   int exp_data;

   // ordered write list of the program
   int seq_add  [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
   int seq_data [8] = '{8'h05, 8'h03, 8'h08, 8'h02, 8'h01, 8'h07, 8'h06, 8'h10};

   fde_cpu dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_stop       (i_stop),
      .o_write_add  (o_write_add),
      .o_write_data (o_write_data)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) reg_m[i] = 0;
      pc_m = 0; run_cnt_m = 0; halt_m = 1'b0; exp_add = 0; exp_data = 0;
   endtask

   task automatic model_exec();
      int w, op, rd, a, b, res;
      bit wr;
      w  = rom_m[pc_m];
      pc_m = (pc_m + 1) % 16;
      op = (w >> 12) & 15;
      rd = (w >> 8) & 15;
      a  = reg_m[(w >> 4) & 15];
      b  = reg_m[w & 15];
      wr = 1'b1;
      res = 0;
      case (op)
         1:  res = w & 255;
         2:  res = (a + b) % 256;
         3:  res = (a - b + 256) % 256;
         4:  res = a & b;
         5:  res = a | b;
         6:  res = a ^ b;
         7:  res = a;
         8:  res = (a * 2) % 256;
         9:  res = a / 2;
         10: begin wr = 1'b0; pc_m = w & 15; end
         11: begin wr = 1'b0; if (a == 0) pc_m = w & 15; end
         15: begin wr = 1'b0; halt_m = 1'b1; end
         default: wr = 1'b0;
      endcase
      if (wr) begin
         reg_m[rd] = res; exp_add = rd; exp_data = res;
      end
   endtask

   task automatic model_edge();
      if (!halt_m) begin
         run_cnt_m++;
         if (run_cnt_m == 3) begin
            run_cnt_m = 0;
            model_exec();
         end
      end
   endtask

   task automatic check(input string tag, input int add, input int data);
      tests_run++;
      assert (o_write_add === add[3:0] && o_write_data === data[7:0]) else begin
         tests_failed++;
         $error("FAIL %s: got %0d/%02h expected %0d/%02h", tag, o_write_add, o_write_data, add, data);
      end
   endtask

   task automatic tick(input logic stop);
      i_stop = stop;
      @(posedge i_clk);
      if (!stop) model_edge();
      @(negedge i_clk);
      check("model", exp_add, exp_data);
   endtask

   initial begin
      int seq_idx;
      logic [3:0] prev_add;
      logic [7:0] prev_data;
      tests_run = 0;
      tests_failed = 0;
      rom_m = '{16'h1105, 16'h1203, 16'h2312, 16'h3412, 16'h4512, 16'h5612,
                16'h6712, 16'h8830, 16'hF000, 0, 0, 0, 0, 0, 0, 0};
      model_reset();
      i_reset = 1'b0;
      i_stop  = 1'b1;
      repeat (3) @(negedge i_clk);
      check("reset", 0, 0);
      i_reset = 1'b1;

      // stopped after reset release: nothing moves
      for (int i = 0; i < 5; i++) tick(1'b1);
      check("stopped_idle", 0, 0);

      repeat (3) tick(1'b0);
      check("first_write", 1, 8'h05);
      tick(1'b0);
      repeat (4) tick(1'b1);
      check("frozen_mid_instr", 1, 8'h05);
      repeat (2) tick(1'b0);
      check("resume_write", 2, 8'h03);

      // asynchronous abort in the middle of instruction 2
      tick(1'b0);
      i_stop = 1'b1;
      #2 i_reset = 1'b0;
      model_reset();
      #1 check("async_reset", 0, 0);
      #1 i_reset = 1'b1;
      @(negedge i_clk);
      check("after_abort_stopped", 0, 0);
      repeat (2) tick(1'b0);
      check("no_early_write", 0, 0);
      tick(1'b0);
      check("restart_write", 1, 8'h05);

      // random stop pattern through the rest of the program and past HALT
      seq_idx = 1;
      prev_add = o_write_add;
      prev_data = o_write_data;
      for (int i = 0; i < 150; i++) begin
         tick(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
         if (o_write_add !== prev_add || o_write_data !== prev_data) begin
            if (seq_idx < 8) begin
               check("write_order", seq_add[seq_idx], seq_data[seq_idx]);
            end else begin
               check("write_after_halt", 8, 8'h10);
            end
            seq_idx++;
            prev_add = o_write_add;
            prev_data = o_write_data;
         end
      end
      tests_run++;
      assert (seq_idx == 8) else begin
         tests_failed++;
         $error("FAIL write_count: got %0d expected %0d", seq_idx, 8);
      end
      repeat (20) tick(1'b0);
      check("halt_hold", 8, 8'h10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
